// File: rtl/bless_inject_ctrl.sv
// bless_inject_ctrl
//   Injection-side controller for a BLESS router node. Flits from the local
//   host are buffered in a small circular FIFO. The head flit is offered to
//   the router with its control word stamped with valid/gold/seq. The block
//   also drives the shared round-robin round and the golden-epoch rotation
//   that decides which node may inject one gold packet per owned epoch.
//
//   Control word layout (CTRL_W bits):
//     [0]                    valid_f
//     [1]                    gold_f
//     [2 +: SEQ_W]           seq_f
//     [CTRL_W-1:SEQ_W+2]     host-defined, passed through untouched
//
//   Ports
//     clk, rst_n          clock, asynchronous active-low reset
//     host_valid/ready    host push handshake (ready = FIFO not full)
//     host_control/data   host flit; valid/gold/seq bits of control ignored
//     host_last           flit closes its packet
//     slot_free           router can take a flit this cycle
//     inj_valid/control/data  head flit offered to the router
//     rr                  2-bit round-robin round
//     epoch_owner         node owning the current golden epoch
module bless_inject_ctrl #(
    parameter int  NODE_ID    = 0,
    parameter int  NUM_NODES  = 16,
    parameter int  EPOCH_LEN  = 64,
    parameter int  FIFO_DEPTH = 4,
    parameter int  DATA_W     = 64,
    parameter int  SEQ_W      = 4,
    parameter int  CTRL_W     = 16,
    localparam int OWN_W      = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [CTRL_W-1:0] host_control,
    input  logic [DATA_W-1:0] host_data,
    input  logic              host_last,
    input  logic              slot_free,
    output logic              inj_valid,
    output logic [CTRL_W-1:0] inj_control,
    output logic [DATA_W-1:0] inj_data,
    output logic [1:0]        rr,
    output logic [OWN_W-1:0]  epoch_owner
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int EW      = $clog2(EPOCH_LEN);
    localparam int VALID_B = 0;
    localparam int GOLD_B  = 1;
    localparam int SEQ_LSB = 2;

    typedef enum logic [1:0] {NORMAL, ARMED, SENDING, DONE} state_t;
    localparam state_t RESET_ST = (NODE_ID == 0) ? ARMED : NORMAL;

    // ---------------- FIFO ----------------
    logic [CTRL_W-1:0]     ctrl_mem [FIFO_DEPTH];
    logic [DATA_W-1:0]     data_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] last_mem;

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic        empty, full, push, inject;
    logic        head_last;
    logic [CTRL_W-1:0] head_ctrl;

    assign empty      = (wr_q == rd_q);
    assign full       = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign host_ready = !full;
    assign push       = host_valid && !full;
    assign inj_valid  = !empty;
    assign inject     = !empty && slot_free;
    assign head_ctrl  = ctrl_mem[rd_q[AW-1:0]];
    assign head_last  = last_mem[rd_q[AW-1:0]];
    assign wr_d       = push   ? wr_q + 1'b1 : wr_q;
    assign rd_d       = inject ? rd_q + 1'b1 : rd_q;

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            ctrl_mem[wr_q[AW-1:0]] <= host_control;
            data_mem[wr_q[AW-1:0]] <= host_data;
            last_mem[wr_q[AW-1:0]] <= host_last;
        end
    end

    // ---------------- counters ----------------
    logic [SEQ_W-1:0] seq_cnt_q, seq_cnt_d;
    logic [1:0]       rr_q, rr_d;
    logic [EW-1:0]    epoch_cnt_q, epoch_cnt_d;
    logic [OWN_W-1:0] owner_q, owner_d, owner_nxt;
    logic             wrap, own_next, own_now;

    assign wrap      = (epoch_cnt_q == EW'(EPOCH_LEN - 1));
    assign owner_nxt = (NUM_NODES == 1) ? '0 : owner_q + 1'b1;
    assign own_next  = (owner_nxt == OWN_W'(NODE_ID));
    assign own_now   = (owner_q == OWN_W'(NODE_ID));

    always_comb begin
        seq_cnt_d = seq_cnt_q;
        if (inject) begin
            if (head_last)       seq_cnt_d = '0;
            else if (!(&seq_cnt_q)) seq_cnt_d = seq_cnt_q + 1'b1;
        end
        rr_d        = rr_q + 2'd1;
        epoch_cnt_d = wrap ? '0 : epoch_cnt_q + 1'b1;
        owner_d     = wrap ? owner_nxt : owner_q;
    end

    // ---------------- gold FSM ----------------
    state_t state_q, state_d;
    logic   pend_q, pend_d;
    logic   gold;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        gold    = 1'b0;
        case (state_q)
            ARMED:   gold = (seq_cnt_q == '0);
            SENDING: gold = 1'b1;
            default: gold = 1'b0;
        endcase
        // Injection transition is resolved first; a wrap in the same cycle
        // then acts on the resulting state.
        if (inject) begin
            case (state_q)
                ARMED: if (seq_cnt_q == '0) state_d = head_last ? DONE : SENDING;
                SENDING: if (head_last) begin
                    // A pended wrap already moved ownership: owner_q is the
                    // owner of the epoch we are now in.
                    state_d = pend_q ? (own_now ? ARMED : NORMAL) : DONE;
                    pend_d  = 1'b0;
                end
                default: ;
            endcase
        end
        if (wrap) begin
            if (state_d == SENDING) begin
                pend_d = 1'b1;   // never truncate a gold packet
            end else begin
                state_d = own_next ? ARMED : NORMAL;
                pend_d  = 1'b0;
            end
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        inj_control = '0;
        inj_data    = '0;
        if (!empty) begin
            inj_control                      = head_ctrl;
            inj_control[VALID_B]             = 1'b1;
            inj_control[GOLD_B]              = gold;
            inj_control[SEQ_LSB +: SEQ_W]    = seq_cnt_q;
            inj_data                         = data_mem[rd_q[AW-1:0]];
        end
    end

    assign rr          = rr_q;
    assign epoch_owner = owner_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q        <= '0;
            rd_q        <= '0;
            seq_cnt_q   <= '0;
            rr_q        <= '0;
            epoch_cnt_q <= '0;
            owner_q     <= '0;
            state_q     <= RESET_ST;
            pend_q      <= 1'b0;
        end else begin
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            seq_cnt_q   <= seq_cnt_d;
            rr_q        <= rr_d;
            epoch_cnt_q <= epoch_cnt_d;
            owner_q     <= owner_d;
            state_q     <= state_d;
            pend_q      <= pend_d;
        end
    end

endmodule

// File: tb/tb_bless_inject_ctrl.sv
// Self-checking bench for bless_inject_ctrl. Two nodes (NODE_ID 0 and 1)
// share one host stream and one slot_free, so FIFO behaviour is identical
// and only gold stamping differs. A queue-based reference model predicts
// every output from the packet/epoch rules.
module tb_bless_inject_ctrl;

    localparam int EL = 8, NN = 4, DEPTH = 4, DW = 16, CW = 16, SW = 4;

    logic clk, rst_n;
    logic host_valid, host_last, slot_free;
    logic [CW-1:0] host_control;
    logic [DW-1:0] host_data;

    logic          hr0, hr1, iv0, iv1;
    logic [CW-1:0] ic0, ic1;
    logic [DW-1:0] id0, id1;
    logic [1:0]    rr0, rr1, eo0, eo1;

    bless_inject_ctrl #(.NODE_ID(0), .NUM_NODES(NN), .EPOCH_LEN(EL), .FIFO_DEPTH(DEPTH),
                        .DATA_W(DW), .SEQ_W(SW), .CTRL_W(CW)) u0 (
        .clk(clk), .rst_n(rst_n), .host_valid(host_valid), .host_ready(hr0),
        .host_control(host_control), .host_data(host_data), .host_last(host_last),
        .slot_free(slot_free), .inj_valid(iv0), .inj_control(ic0), .inj_data(id0),
        .rr(rr0), .epoch_owner(eo0));

    bless_inject_ctrl #(.NODE_ID(1), .NUM_NODES(NN), .EPOCH_LEN(EL), .FIFO_DEPTH(DEPTH),
                        .DATA_W(DW), .SEQ_W(SW), .CTRL_W(CW)) u1 (
        .clk(clk), .rst_n(rst_n), .host_valid(host_valid), .host_ready(hr1),
        .host_control(host_control), .host_data(host_data), .host_last(host_last),
        .slot_free(slot_free), .inj_valid(iv1), .inj_control(ic1), .inj_data(id1),
        .rr(rr1), .epoch_owner(eo1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0][37:0] obs;
    assign obs[0] = {iv0, hr0, ic0, id0, rr0, eo0};
    assign obs[1] = {iv1, hr1, ic1, id1, rr1, eo1};

    int n_cmp = 0, n_bad = 0;

    // ---------------- reference model ----------------
    typedef struct packed { logic [CW-1:0] c; logic [DW-1:0] d; logic l; } flit_t;
    flit_t mq [$];
    int    cyc, pos;             // cycles since reset release; flits sent of current packet
    bit    gpkt [2];             // node is in the middle of a gold packet
    bit    used [2];             // node already started its gold packet this epoch
    bit    pend [2];             // an epoch boundary passed during that gold packet

    // host stream
    int    len_q [$];
    int    len_max = 6, pkt_rem = 0, pushed = 0;
    logic [DW-1:0] push_log [$];

    function automatic int cur_owner();
        return (cyc / EL) % NN;
    endfunction

    function automatic logic exp_gold(int n);
        if (mq.size() == 0) return 1'b0;
        return gpkt[n] || (pos == 0 && cur_owner() == n && !used[n]);
    endfunction

    function automatic logic [37:0] exp_vec(int n);
        logic [CW-1:0] c;
        logic [DW-1:0] d;
        int s;
        c = '0; d = '0;
        s = (pos > 15) ? 15 : pos;
        if (mq.size() > 0) begin
            c = {mq[0].c[CW-1:6], 4'(s), exp_gold(n), 1'b1};
            d = mq[0].d;
        end
        return {mq.size() > 0, mq.size() < DEPTH, c, d, 2'(cyc % 4), 2'(cur_owner())};
    endfunction

    task automatic gen_flit();
        if (pkt_rem == 0)
            pkt_rem = (len_q.size() > 0) ? len_q.pop_front() : int'($urandom_range(1, len_max));
        host_control = CW'($urandom);
        host_data    = DW'($urandom);
        host_last    = (pkt_rem == 1);
        pkt_rem--;
    endtask

    // Advance the model across the coming rising edge, then move to the
    // next falling edge where the host may present a new flit.
    task automatic tick();
        bit push, pop;
        flit_t f;
        push = 1'b0; pop = 1'b0;
        if (rst_n) begin
            push = host_valid && (mq.size() < DEPTH);
            pop  = (mq.size() > 0) && slot_free;
            if (pop) begin
                f = mq[0];
                for (int n = 0; n < 2; n++) begin
                    if (!gpkt[n] && exp_gold(n)) begin
                        used[n] = 1'b1;
                        gpkt[n] = !f.l;
                    end else if (gpkt[n] && f.l) begin
                        gpkt[n] = 1'b0;
                        if (pend[n]) begin pend[n] = 1'b0; used[n] = 1'b0; end
                    end
                end
                pos = f.l ? 0 : pos + 1;
                void'(mq.pop_front());
            end
            if (push) begin
                f.c = host_control; f.d = host_data; f.l = host_last;
                mq.push_back(f);
            end
            if (cyc % EL == EL - 1)
                for (int n = 0; n < 2; n++) begin
                    if (gpkt[n]) pend[n] = 1'b1;
                    else         used[n] = 1'b0;
                end
            cyc++;
        end
        @(negedge clk);
        if (push) begin
            pushed++;
            push_log.push_back(host_data);
            gen_flit();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; host_valid = 1'b0; slot_free = 1'b0;
        mq.delete(); push_log.delete();
        cyc = 0; pos = 0; pushed = 0; pkt_rem = 0;
        for (int n = 0; n < 2; n++) begin gpkt[n] = 0; used[n] = 0; pend[n] = 0; end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        gen_flit();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [1:0] exp_rr [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        n_cmp++;
        if ({iv0, hr0, ic0, id0, rr0, eo0} !== {1'b0, 1'b1, 36'b0}) begin
            n_bad++; $display("FAIL reset_n0: got %h want %h", {iv0, hr0, ic0, id0, rr0, eo0}, {1'b0, 1'b1, 36'b0});
        end
        n_cmp++;
        if ({iv1, hr1, ic1, id1, rr1, eo1} !== {1'b0, 1'b1, 36'b0}) begin
            n_bad++; $display("FAIL reset_n1: got %h want %h", {iv1, hr1, ic1, id1, rr1, eo1}, {1'b0, 1'b1, 36'b0});
        end
        host_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 2; n++) begin
                n_cmp++;
                if (obs[n] !== exp_vec(n)) begin
                    n_bad++; $display("FAIL fill n%0d cyc %0d: got %h want %h", n, cyc, obs[n], exp_vec(n));
                end
            end
            tick();
        end
        // three flits buffered: assert reset mid-cycle
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({iv0, ic0, hr0, iv1, ic1, hr1} !== {1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b1}) begin
            n_bad++; $display("FAIL async_reset: got %h want %h", {iv0, ic0, hr0, iv1, ic1, hr1},
                              {1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b1});
        end
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({rr0, rr1} !== {exp_rr[i], exp_rr[i]}) begin
                n_bad++; $display("FAIL rr_seq[%0d]: got %0d/%0d want %0d", i, rr0, rr1, exp_rr[i]);
            end
            tick();
        end
    endtask

    task automatic test_gold_stamping();
        logic [5:0] exp_r [5] = '{6'b0000_10, 6'b0001_10, 6'b0010_10, 6'b0000_00, 6'b0001_00};
        logic [5:0] rec [$];
        len_q = '{3, 2};
        do_reset();
        host_valid = 1'b1; slot_free = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (pushed >= 5) host_valid = 1'b0;
            for (int n = 0; n < 2; n++) begin
                n_cmp++;
                if (obs[n] !== exp_vec(n)) begin
                    n_bad++; $display("FAIL stamp n%0d cyc %0d: got %h want %h", n, cyc, obs[n], exp_vec(n));
                end
            end
            if (iv0 && slot_free) rec.push_back({ic0[5:2], ic0[1], ic1[1]});
            tick();
        end
        n_cmp++;
        if (rec.size() != 5) begin
            n_bad++; $display("FAIL stamp_count: got %0d want 5", rec.size());
        end
        for (int i = 0; i < 5 && i < rec.size(); i++) begin
            n_cmp++;
            if (rec[i] !== exp_r[i]) begin
                n_bad++; $display("FAIL stamp_flit[%0d] {seq,g0,g1}: got %b want %b", i, rec[i], exp_r[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] drained [$];
        int dcyc [$];
        len_q = '{5};
        do_reset();
        host_valid = 1'b1; slot_free = 1'b0;
        for (int i = 0; i < 6; i++) begin
            for (int n = 0; n < 2; n++) begin
                n_cmp++;
                if (obs[n] !== exp_vec(n)) begin
                    n_bad++; $display("FAIL bp_hold n%0d cyc %0d: got %h want %h", n, cyc, obs[n], exp_vec(n));
                end
            end
            tick();
        end
        n_cmp++;
        if ({hr0, iv0, id0} !== {1'b0, 1'b1, push_log[0]}) begin
            n_bad++; $display("FAIL bp_full {ready,valid,data}: got %h want %h", {hr0, iv0, id0}, {1'b0, 1'b1, push_log[0]});
        end
        slot_free = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (pushed >= 5) host_valid = 1'b0;
            for (int n = 0; n < 2; n++) begin
                n_cmp++;
                if (obs[n] !== exp_vec(n)) begin
                    n_bad++; $display("FAIL bp_drain n%0d cyc %0d: got %h want %h", n, cyc, obs[n], exp_vec(n));
                end
            end
            if (iv0 && slot_free) begin drained.push_back(id0); dcyc.push_back(cyc); end
            tick();
        end
        n_cmp++;
        if (drained.size() != 5 || push_log.size() < 5) begin
            n_bad++; $display("FAIL bp_count: got %0d want 5", drained.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (drained[i] !== push_log[i] || dcyc[i] != 6 + i) begin
                    n_bad++; $display("FAIL bp_order[%0d]: got %h@%0d want %h@%0d", i, drained[i], dcyc[i], push_log[i], 6 + i);
                end
            end
        end
    endtask

    task automatic test_rotation();
        logic [1:0] exp_own [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        for (int c = 0; c <= 32; c++) begin
            for (int n = 0; n < 2; n++) begin
                n_cmp++;
                if (obs[n] !== exp_vec(n)) begin
                    n_bad++; $display("FAIL rot n%0d cyc %0d: got %h want %h", n, cyc, obs[n], exp_vec(n));
                end
            end
            if (c > 0 && c % 8 == 0) begin
                n_cmp++;
                if ({eo0, eo1} !== {exp_own[c/8-1], exp_own[c/8-1]}) begin
                    n_bad++; $display("FAIL owner@%0d: got %0d/%0d want %0d", c, eo0, eo1, exp_own[c/8-1]);
                end
            end
            tick();
        end
    endtask

    // Gold 4-flit packet from node 0 starts at cycle 6 and crosses the epoch
    // boundary; node 1 gains ownership while that packet is mid-flight.
    task automatic test_wrap_scenario(input bit toggle);
        logic [1:0] exp_g [6] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
        logic [1:0] rec [$];
        len_q = '{4, 2};
        do_reset();
        host_valid = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (pushed >= 6) host_valid = 1'b0;
            slot_free = toggle ? (cyc >= 6 && cyc % 2 == 0) : (cyc >= 6);
            for (int n = 0; n < 2; n++) begin
                n_cmp++;
                if (obs[n] !== exp_vec(n)) begin
                    n_bad++; $display("FAIL wrap%0d n%0d cyc %0d: got %h want %h", toggle, n, cyc, obs[n], exp_vec(n));
                end
            end
            if (iv0 && slot_free) rec.push_back({ic0[1], ic1[1]});
            tick();
        end
        n_cmp++;
        if (rec.size() != 6) begin
            n_bad++; $display("FAIL wrap%0d_count: got %0d want 6", toggle, rec.size());
        end
        for (int i = 0; i < 6 && i < rec.size(); i++) begin
            n_cmp++;
            if (rec[i] !== exp_g[i]) begin
                n_bad++; $display("FAIL wrap%0d_gold[%0d] {g0,g1}: got %b want %b", toggle, i, rec[i], exp_g[i]);
            end
        end
    endtask

    task automatic test_random();
        int hv_pct, sf_pct;
        len_max = 20;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                hv_pct = $urandom_range(20, 100);
                sf_pct = $urandom_range(10, 100);
            end
            if (i == 1500) begin
                @(negedge clk);
                do_reset();
            end
            host_valid = ($urandom_range(0, 99) < hv_pct);
            slot_free  = ($urandom_range(0, 99) < sf_pct);
            for (int n = 0; n < 2; n++) begin
                n_cmp++;
                if (obs[n] !== exp_vec(n)) begin
                    n_bad++; $display("FAIL rand n%0d cyc %0d: got %h want %h", n, cyc, obs[n], exp_vec(n));
                end
            end
            tick();
        end
        len_max = 6;
    endtask

    initial begin
        rst_n = 1'b0; host_valid = 1'b0; slot_free = 1'b0;
        host_control = '0; host_data = '0; host_last = 1'b0;
        test_reset();
        test_gold_stamping();
        test_backpressure();
        test_rotation();
        test_wrap_scenario(1'b1);
        test_wrap_scenario(1'b0);
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
